// File: rtl/regfile_loader_pkg.sv
// Shared types and widths for the register-file loader.
// Imported by the loader, its write mux and the byte interface.
package regfile_loader_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
// master is the byte source, slave is the loader.
interface regfile_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/regfile_write_mux.sv
// Selects who owns the regfile write port:
// the processor when idle, the loader while busy.
module regfile_write_mux
  import regfile_loader_pkg::*;
(
  input  logic                  sel,
  input  logic                  cpu_we,
  input  logic [REG_ADDR_W-1:0] cpu_reg,
  input  logic [WORD_W-1:0]     cpu_data,
  input  logic                  ld_we,
  input  logic [REG_ADDR_W-1:0] ld_reg,
  input  logic [WORD_W-1:0]     ld_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wreg,
  output logic [WORD_W-1:0]     wdata
);

  always_comb begin
    we    = cpu_we;
    wreg  = cpu_reg;
    wdata = cpu_data;
    if (sel) begin
      we    = ld_we;
      wreg  = ld_reg;
      wdata = ld_data;
    end
  end

endmodule

// File: rtl/regfile_loader.sv
// Loads registers FIRST_REG..LAST_REG from a byte stream,
// holding the processor in reset and owning the write port.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  regfile_loader_if.slave       byte_in,
  input  logic                  cpu_writeEnable,
  input  logic [REG_ADDR_W-1:0] cpu_writeReg,
  input  logic [WORD_W-1:0]     cpu_dataWrite,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [WORD_W-1:0]     data_writeReg,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST =
    REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST =
    REG_ADDR_W'(LAST_REG);
  localparam logic [REG_ADDR_W-1:0] ONE_R = 1;
  localparam logic [BYTE_CNT_W-1:0] ONE_B = 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE =
    BYTE_CNT_W'(BYTES_PER_WORD - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [REG_ADDR_W-1:0]   reg_idx;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic [WORD_W-1:0]       word;
  logic                    take;
  logic                    last_reg;

  assign byte_in.in_ready = (state == RECV);
  assign busy             = (state != IDLE);
  assign take     = byte_in.in_valid && byte_in.in_ready;
  assign last_reg = (reg_idx == LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RECV;
      RECV:    if (take && byte_cnt == LAST_BYTE)
                 state_nx = WRITE;
      WRITE:   state_nx = last_reg ? IDLE : RECV;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_idx   <= FIRST;
      byte_cnt  <= '0;
      word      <= '0;
      done      <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      done      <= (state == WRITE) && last_reg;
      cpu_reset <= busy;
      unique case (state)
        IDLE: if (start) begin
          reg_idx  <= FIRST;
          byte_cnt <= '0;
          word     <= '0;
        end
        RECV: if (take) begin
          word[{byte_cnt, 3'b000} +: 8] <= byte_in.in_data;
          byte_cnt <= byte_cnt + ONE_B;
        end
        WRITE: if (!last_reg) reg_idx <= reg_idx + ONE_R;
        default: ;
      endcase
    end
  end

  regfile_write_mux u_mux (
    .sel      (busy),
    .cpu_we   (cpu_writeEnable),
    .cpu_reg  (cpu_writeReg),
    .cpu_data (cpu_dataWrite),
    .ld_we    (state == WRITE),
    .ld_reg   (reg_idx),
    .ld_data  (word),
    .we       (ctrl_writeEnable),
    .wreg     (ctrl_writeReg),
    .wdata    (data_writeReg)
  );

endmodule

// File: tb/tb_regfile_loader.sv
// Directed + randomized bench for regfile_loader against
// a word-level model of the register file contents.
module tb_regfile_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // main DUT: r1..r31
  logic        reset, start;
  logic        cpu_we;
  logic [4:0]  cpu_reg;
  logic [31:0] cpu_data;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        cpu_rst, busy, done;
  regfile_loader_if bi ();

  regfile_loader #(.FIRST_REG(1), .LAST_REG(31)) dut (
    .clock            (clk),
    .reset            (reset),
    .start            (start),
    .byte_in          (bi),
    .cpu_writeEnable  (cpu_we),
    .cpu_writeReg     (cpu_reg),
    .cpu_dataWrite    (cpu_data),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wreg),
    .data_writeReg    (wdata),
    .cpu_reset        (cpu_rst),
    .busy             (busy),
    .done             (done)
  );

  // single-register DUT: r7 only
  logic        reset7, start7;
  logic        we7;
  logic [4:0]  wreg7;
  logic [31:0] wdata7;
  logic        cpu_rst7, busy7, done7;
  logic        cpu_we7 = 1'b0;
  logic [4:0]  cpu_reg7 = 5'd0;
  logic [31:0] cpu_data7 = 32'd0;
  regfile_loader_if bi7 ();

  regfile_loader #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
    .clock            (clk),
    .reset            (reset7),
    .start            (start7),
    .byte_in          (bi7),
    .cpu_writeEnable  (cpu_we7),
    .cpu_writeReg     (cpu_reg7),
    .cpu_dataWrite    (cpu_data7),
    .ctrl_writeEnable (we7),
    .ctrl_writeReg    (wreg7),
    .data_writeReg    (wdata7),
    .cpu_reset        (cpu_rst7),
    .busy             (busy7),
    .done             (done7)
  );

  // bench regfile fed only by the loader's output port
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic [31:0] words [32];
  int r9_writes = 0;
  int w7_count  = 0;
  logic [31:0] w7_data = 0;

  initial for (int i = 0; i < 32; i++) rf[i] = 0;

  always @(posedge clk) begin
    if (we && wreg != 5'd0) rf[wreg] <= wdata;
    if (we && wreg == 5'd9) r9_writes <= r9_writes + 1;
    if (we7) begin
      w7_count <= w7_count + 1;
      w7_data  <= wdata7;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", tag, i), rf[i], exp_rf[i]);
  endtask

  // One load on the main DUT. stall_*: idle gap before a
  // byte; glitch_r: start pulse mid-load; abort_*: reset
  // after that byte (0 = none).
  task automatic run_load(input int stall_r, stall_b,
                          stall_n, glitch_r,
                          abort_r, abort_b,
                          input bit noise);
    int lat;
    int r9_0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (noise) begin
      cpu_we = 1'b1; cpu_reg = 5'd9;
      cpu_data = 32'hBAD0BAD0;
    end
    r9_0 = r9_writes;
    lat  = 0;
    check("busy_on", busy, 1);
    for (int r = 1; r <= 31; r++) begin
      for (int b = 0; b < 4; b++) begin
        if (r == stall_r && b == stall_b)
          repeat (stall_n) begin
            bi.in_valid = 1'b0;
            check("stall_ready", bi.in_ready, 1);
            step();
            lat++;
          end
        bi.in_valid = 1'b1;
        bi.in_data  = words[r][8*b +: 8];
        start = (r == glitch_r && b == 1);
        check("recv_ready", bi.in_ready, 1);
        check("recv_we", we, 0);
        check("recv_done", done, 0);
        step();
        lat++;
        start = 1'b0;
        if (r == abort_r && b == abort_b) begin
          bi.in_valid = 1'b0;
          reset = 1'b1;
          step();
          reset = 1'b0;
          cpu_we = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_ready", bi.in_ready, 0);
          check("abort_done", done, 0);
          step();
          check("abort_done2", done, 0);
          return;
        end
      end
      bi.in_valid = 1'b1;
      bi.in_data  = 8'hAA;
      check("wr_ready", bi.in_ready, 0);
      check("wr_we", we, 1);
      check($sformatf("wr_reg%0d", r), wreg, r);
      check($sformatf("wr_data%0d", r), wdata, words[r]);
      exp_rf[r] = words[r];
      step();
      lat++;
    end
    bi.in_valid = 1'b0;
    cpu_we = 1'b0;
    check("done_pulse", done, 1);
    check("latency", lat,
          155 + ((stall_r != 0) ? stall_n : 0));
    check("busy_off", busy, 0);
    check("cpu_rst_hold", cpu_rst, 1);
    step();
    check("done_clear", done, 0);
    check("cpu_rst_rel", cpu_rst, 0);
    if (noise) check("r9_writes", r9_writes - r9_0, 1);
  endtask

  initial begin
    logic [31:0] w7;
    for (int i = 0; i < 32; i++) exp_rf[i] = 0;
    reset = 1'b1; start = 1'b0;
    reset7 = 1'b1; start7 = 1'b0;
    bi.in_valid = 1'b0; bi.in_data = 8'h00;
    bi7.in_valid = 1'b0; bi7.in_data = 8'h00;
    cpu_we = 1'b1; cpu_reg = 5'd5; cpu_data = 32'h1234;
    repeat (3) step();
    check("rst_cpu_reset", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", bi.in_ready, 0);
    check("rst_done", done, 0);
    check("rst_pass_we", we, 1);
    check("rst_pass_reg", wreg, 5);
    check("rst_pass_data", wdata, 32'h1234);
    exp_rf[5] = 32'h1234;
    reset = 1'b0; reset7 = 1'b0;
    cpu_we = 1'b0;
    step();
    check("idle_cpu_reset", cpu_rst, 0);
    bi.in_valid = 1'b1; bi.in_data = 8'h55;
    check("idle_ready", bi.in_ready, 0);
    step();
    bi.in_valid = 1'b0;

    // fixed pattern with processor write noise on r9
    for (int r = 0; r < 32; r++) words[r] = 32'h12345678;
    run_load(0, 0, 0, 0, 0, 0, 1'b1);
    check_rf("fixed");
    check("fixed_r1_dec", rf[1], 305419896);

    // random words, 7-cycle stall after 2nd byte of r3,
    // start glitch while busy on r2
    for (int r = 0; r < 32; r++) words[r] = $urandom;
    run_load(3, 2, 7, 2, 0, 0, 1'b0);
    check_rf("stall");

    // reset after 2nd byte of r4
    for (int r = 0; r < 32; r++) words[r] = $urandom;
    run_load(0, 0, 0, 0, 4, 1, 1'b0);
    check_rf("abort");

    // reload from r1 after the abort
    for (int r = 0; r < 32; r++) words[r] = $urandom;
    run_load(0, 0, 0, 0, 0, 0, 1'b0);
    check_rf("reload");

    // start and reset together
    start = 1'b1; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    check("rs_busy", busy, 0);
    step();
    check("rs_busy2", busy, 0);
    check("rs_ready", bi.in_ready, 0);

    // single-register loader
    w7 = 32'hDEADBEEF;
    start7 = 1'b1;
    step();
    start7 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bi7.in_valid = 1'b1;
      bi7.in_data  = w7[8*b +: 8];
      check("one_done_early", done7, 0);
      step();
    end
    bi7.in_valid = 1'b0;
    check("one_we", we7, 1);
    check("one_reg", wreg7, 7);
    check("one_data", wdata7, 32'hDEADBEEF);
    step();
    check("one_done", done7, 1);
    check("one_busy", busy7, 0);
    check("one_count", w7_count, 1);
    check("one_wdata", w7_data, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Hardware counterpart of the bench's register-dump harness. Where the bench reads the register file out, this block writes initial values into it.
- It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- It takes over the register-file write port, bypassing the processor, and writes the words into registers FIRST_REG..LAST_REG in order.
- It holds the processor in reset while loading. It sits between the processor, my_regfile and a byte source such as a UART receiver.

Parameters:
- FIRST_REG, 1, first register index written; register 0 is never written.
- LAST_REG, 31, last register index written; requires FIRST_REG <= LAST_REG <= 31.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled in IDLE only.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte from the source.
- in_ready  out  1  loader accepts a byte this cycle.
- cpu_writeEnable  in  1  processor's ctrl_writeEnable.
- cpu_writeReg  in  5  processor's ctrl_writeReg.
- cpu_dataWrite  in  32  processor's data_writeReg.
- ctrl_writeEnable  out  1  to the regfile.
- ctrl_writeReg  out  5  to the regfile.
- data_writeReg  out  32  to the regfile.
- cpu_reset  out  1  reset to the processor.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset:
  - state is IDLE; reg_idx is FIRST_REG; byte_cnt is 0; word is 0.
  - in_ready=0, busy=0, done=0, cpu_reset=1.
  - Regfile outputs pass through from the cpu_* inputs.
- cpu_reset = reset | busy, registered.
  - Deasserts on the cycle after the load completes.
- States: IDLE, RECV, WRITE.
- IDLE:
  - busy=0, in_ready=0, regfile port muxed to cpu_*.
  - start=1 -> RECV next cycle; busy=1; reg_idx=FIRST_REG; byte_cnt=0; word=0.
- RECV:
  - in_ready=1, combinational from state.
  - A byte is accepted when in_valid && in_ready. It goes into word[8*byte_cnt +: 8], LSB first, and byte_cnt increments.
  - in_valid=0 stalls indefinitely with no timeout.
  - On acceptance of the 4th byte (byte_cnt==3) -> WRITE next cycle; byte_cnt=0.
- WRITE, exactly one cycle:
  - in_ready=0, ctrl_writeEnable=1, ctrl_writeReg=reg_idx, data_writeReg=word.
  - If reg_idx==LAST_REG -> IDLE; done=1 for the next cycle; busy=0 next cycle.
  - Otherwise reg_idx++ and -> RECV.
- Write port while busy: cpu_* inputs are ignored and ctrl_writeEnable is driven 0 except in WRITE. A processor held in reset must not write.
- Latency:
  - 5 cycles per register at full source rate: 4 RECV plus 1 WRITE.
  - Full 31-register load: 155 cycles from the first RECV cycle to done.
- Boundary conditions:
  - start while busy is ignored.
  - start and reset in the same cycle: reset wins.
  - reset mid-load: immediately IDLE; the partial word is discarded; already-written registers are not undone; done is not pulsed.
  - Bytes presented while in IDLE or WRITE are not consumed (in_ready=0).
  - FIRST_REG==LAST_REG: a single-word load, 5 cycles.
- No arithmetic beyond the 5-bit reg_idx increment and the 2-bit byte_cnt, which wraps 3->0.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2);
  - REG_ADDR_W=5, WORD_W=32, BYTES_PER_WORD=4.
- One natural sub-module, regfile_write_mux: a 2:1 mux on {writeEnable, writeReg, data} selected by busy. Everything else stays in the top.

Test Plan:
- Reset held 3 cycles -> cpu_reset=1, busy=0, in_ready=0, done=0; cpu_writeEnable=1, cpu_writeReg=5, cpu_dataWrite=0x1234 appear unchanged on the regfile port.
- start, then bytes 0x78,0x56,0x34,0x12 for r1..r31 back-to-back at full rate:
  - each WRITE shows data_writeReg=0x12345678 with the correct index;
  - done pulses at cycle 155;
  - the bench's register readout gives r1..r31=305419896 and r0=0.
- Source drops in_valid for 7 cycles after the 2nd byte of r3 -> in_ready stays 1; word for r3 is still correct; total load is 162 cycles.
- cpu_writeEnable=1, cpu_writeReg=9 driven during a load -> no regfile write to r9 except the loader's own WRITE cycle for r9.
- reset asserted after the 2nd byte of r4 -> next cycle IDLE, in_ready=0, no done. A new start then loads from r1 again with byte_cnt=0.
- start asserted while busy, and start with reset in the same cycle -> both ignored (no restart, state stays IDLE respectively). With FIRST_REG=LAST_REG=7, a single word 0xDEADBEEF gives one write to r7 and done 5 cycles after RECV entry.
